serial_compare_unit: RTL and testbench
======================================

# serial_compare_unit

Multi-cycle magnitude comparator for the ALU set-less-than path. It latches two WIDTH-bit operands on a start pulse and scans them MSB-first, one bit per clock, stopping at the first differing bit. It reports a registered 1-bit `lt` flag and an `eq` flag with a done pulse. The `lt` bit feeds the 1-bit-to-32-bit widening stage that forms the SLT/SLTU result word.

## Interface
- `WIDTH`, default 32: operand width; must be ≥ 2.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high; clears all state on the next rising edge.
- `start` in 1: request a compare. Accepted only in IDLE or DONE.
- `a` in WIDTH: operand A, sampled on the accepting edge.
- `b` in WIDTH: operand B, sampled on the accepting edge.
- `is_signed` in 1: 1 selects two's-complement compare (SLT), 0 selects unsigned (SLTU). Sampled with the operands.
- `busy` out 1: high while in SCAN.
- `done` out 1: single-cycle pulse; result valid.
- `lt` out 1: A < B under the latched signedness. Registered; holds until the next accepted start.
- `eq` out 1: A == B. Registered; holds until the next accepted start.

## Operation
- Reset value of every output: `busy`=0, `done`=0, `lt`=0, `eq`=0. State = IDLE, index = 0, operand registers = 0.
- States:
  - IDLE: waits for `start`. On `start`=1: latch `a`, `b`, `is_signed`; set index=WIDTH-1; clear `lt`/`eq`; go to SCAN.
  - SCAN: examines bit[index] of the latched A and B.
    - If the bits differ: set `lt`, set `eq`=0, go to DONE.
    - If the bits are equal and index==0: set `lt`=0, `eq`=1, go to DONE.
    - Otherwise: decrement index and stay in SCAN.
  - DONE: `done`=1 for exactly this cycle. Next state is SCAN if `start`=1 (new operands latched as in IDLE), else IDLE.
- Decision rule at the first differing bit i:
  - Unsigned, or signed with i < WIDTH-1: `lt` = B[i] (that is, A[i]=0).
  - Signed with i == WIDTH-1 (sign bits differ): `lt` = A[i] (A is negative).
- `start` while in SCAN is ignored. The operation is not restarted and no operands are re-latched.
- Input operands may change freely after the accepting edge; only the latched copies are used.
- Reset asserted mid-SCAN aborts the operation: the state returns to IDLE with all outputs 0. No `done` pulse is issued.
- Reset and `start` asserted on the same edge: reset wins.
- The index never wraps below 0. The equal-at-bit-0 case terminates the scan.

## Timing
- Edge numbering: the accepting edge is E0.
- The bit at index i is evaluated on edge E(WIDTH-i).
- `done`, `lt` and `eq` are visible in the cycle after that evaluation edge.
- Latency from the accepting edge to the `done` cycle:
  - Minimum: 1 evaluation edge (MSBs differ).
  - Maximum: WIDTH evaluation edges (operands equal, or differing only at bit 0).
- `busy` is 1 from the cycle after E0 through the cycle of the final evaluation edge. It is 0 during the DONE cycle.
- Back-to-back operation: a `start` during the DONE cycle is accepted on the following edge. There is no idle bubble.
- `lt`/`eq` are combinationally stable (register outputs) and are safe to feed directly into the widening stage.

## Structure
- Shared ALU package holds:
  - the state enum (IDLE, SCAN, DONE; 2-bit encoding);
  - the `WIDTH` default constant 32;
  - the index width constant, $clog2(WIDTH).
- One sub-module, `compare_bit_cell`: combinational. Inputs are a_bit, b_bit, is_msb and is_signed. Outputs are `differ` and `lt_here`.
- The top level holds the FSM, the operand registers, the down-counter and the result registers.

## Test plan
- Signed compare, A=0xFFFFFFFF (−1), B=0x00000001 → `lt`=1, `eq`=0. `done` one cycle after E1 (the MSBs differ).
- Unsigned compare, same operands → `lt`=0, `eq`=0, with the same latency.
- Equal operands, A=B=0x12345678, signed → `eq`=1, `lt`=0. `done` in the cycle after E32; `busy` high for exactly 32 cycles.
- Operands differing only at bit 0, A=0x10, B=0x11, unsigned → `lt`=1 after 32 evaluation edges.
  - While busy, pulse `start` with A=0, B=5: it must be ignored and the result unchanged.
  - Then assert `start` during the DONE cycle with new operands: the next SCAN begins immediately.
- Reset at the 10th cycle of a scan → in the next cycle `busy`=`done`=`lt`=`eq`=0 and state=IDLE. No `done` pulse follows.
- Reset and `start` asserted on the same edge → the start is dropped and all outputs remain 0.

Source files
------------

// File: rtl/serial_compare_unit_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM states and sizing constants.
package serial_compare_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEFAULT = 32;
    localparam int INDEX_WIDTH   = $clog2(WIDTH_DEFAULT);

    // Bit-index counter width for an arbitrary operand width (never below 1).
    function automatic int index_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_compare_unit_compare_bit_cell.sv
// Single-bit compare cell: flags a differing bit and the lt decision it implies.
module compare_bit_cell
    import serial_compare_unit_pkg::*;
(
    input  logic a_bit,
    input  logic b_bit,
    input  logic is_msb,
    input  logic is_signed,
    output logic differ,
    output logic lt_here
);

    assign differ = a_bit ^ b_bit;

    // Differing sign bits: the negative operand (A set) is the smaller one.
    assign lt_here = (is_signed && is_msb) ? a_bit : b_bit;

endmodule

// File: rtl/serial_compare_unit.sv
// MSB-first bit-serial magnitude comparator producing registered lt/eq for SLT/SLTU.
module serial_compare_unit
    import serial_compare_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq
);

    localparam int             IW        = index_width(WIDTH);
    localparam logic [IW-1:0]  MSB_INDEX = IW'(WIDTH - 1);

    state_t           state_reg;
    logic [IW-1:0]    index_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             signed_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             lt_reg;
    logic             eq_reg;

    logic             bit_differ;
    logic             bit_lt;

    compare_bit_cell u_cell (
        .a_bit     (a_reg[index_reg]),
        .b_bit     (b_reg[index_reg]),
        .is_msb    (index_reg == MSB_INDEX),
        .is_signed (signed_reg),
        .differ    (bit_differ),
        .lt_here   (bit_lt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            index_reg  <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            signed_reg <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            lt_reg     <= 1'b0;
            eq_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    // DONE accepts a new start directly so back-to-back compares have no bubble.
                    if (start) begin
                        a_reg      <= a;
                        b_reg      <= b;
                        signed_reg <= is_signed;
                        index_reg  <= MSB_INDEX;
                        lt_reg     <= 1'b0;
                        eq_reg     <= 1'b0;
                        busy_reg   <= 1'b1;
                        state_reg  <= SCAN;
                    end else begin
                        state_reg  <= IDLE;
                    end
                end
                SCAN: begin
                    if (bit_differ) begin
                        lt_reg    <= bit_lt;
                        eq_reg    <= 1'b0;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= DONE;
                    end else if (index_reg == '0) begin
                        lt_reg    <= 1'b0;
                        eq_reg    <= 1'b1;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= DONE;
                    end else begin
                        index_reg <= index_reg - 1'b1;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign lt   = lt_reg;
    assign eq   = eq_reg;

endmodule

// File: tb/tb_serial_compare_unit.sv
// Bench for serial_compare_unit: directed table, randomized model checks, and control corner cases.
module tb_serial_compare_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         is_signed;
    logic         busy;
    logic         done;
    logic         lt;
    logic         eq;

    int n_vec  = 0;
    int n_miss = 0;

    serial_compare_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .busy      (busy),
        .done      (done),
        .lt        (lt),
        .eq        (eq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sgn;
        logic         exp_lt;
        logic         exp_eq;
        int           exp_lat;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic compare, latency from position of highest differing bit.
    function automatic logic ref_lt(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        if (s) return $signed(x) < $signed(y);
        return x < y;
    endfunction

    function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] d;
        d = x ^ y;
        for (int i = W - 1; i >= 0; i--)
            if (d[i]) return W - i;
        return W;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands and start across one edge (E0); operands are scrambled afterwards.
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        a = x; b = y; is_signed = s; start = 1'b1;
        tick();
        start = 1'b0;
        a = $urandom; b = $urandom; is_signed = $urandom_range(0, 1);
    endtask

    // Waits for done; optionally injects a start pulse while busy at cycle inject_at.
    task automatic wait_done(input int inject_at, output int lat, output int busy_cycles);
        bit injected;
        injected    = 1'b0;
        lat         = -1;
        busy_cycles = busy ? 1 : 0;
        for (int c = 1; c <= W + 4; c++) begin
            tick();
            if (injected) begin
                start = 1'b0;
                injected = 1'b0;
            end
            if (done) begin
                lat = c;
                break;
            end
            if (busy) busy_cycles++;
            if (c == inject_at) begin
                a = '0; b = 32'd5; is_signed = 1'b0; start = 1'b1;
                injected = 1'b1;
            end
        end
        start = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic s, input logic elt, input logic eeq, input int elat,
                          input int inject_at);
        int lat, bc;
        start_op(x, y, s);
        wait_done(inject_at, lat, bc);
        $display("op %s a=%08h b=%08h signed=%0d lt=%0d eq=%0d latency=%0d", name, x, y, s, lt, eq, lat);
        check({name, " latency"}, lat, elat);
        check({name, " busy_cycles"}, bc, elat);
        check({name, " lt"}, lt, elt);
        check({name, " eq"}, eq, eeq);
        check({name, " busy_at_done"}, busy, 0);
    endtask

    vec_t vecs[7];

    initial begin
        int lat, bc, pulses;
        logic [W-1:0] x, y;
        logic s;

        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 1};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1};
        vecs[2] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 32};
        vecs[3] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1};
        vecs[4] = '{32'h0000_0005, 32'hFFFF_FFFD, 1'b1, 1'b0, 1'b0, 1};
        vecs[5] = '{32'hFFFF_FFFB, 32'hFFFF_FFFD, 1'b1, 1'b1, 1'b0, 30};
        vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32};

        reset = 1'b1; start = 1'b0; a = '0; b = '0; is_signed = 1'b0;
        repeat (3) tick();
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset lt", lt, 0);
        check("reset eq", eq, 0);
        reset = 1'b0;
        tick();

        foreach (vecs[i]) begin
            run_op($sformatf("table%0d", i), vecs[i].a, vecs[i].b, vecs[i].sgn,
                   vecs[i].exp_lt, vecs[i].exp_eq, vecs[i].exp_lat, -1);
            tick();
            check("done_pulse_single", done, 0);
            check("lt_hold", lt, vecs[i].exp_lt);
        end

        // Differ only at bit 0, with an ignored start mid-scan, then back-to-back start in DONE.
        run_op("bit0_ignore_start", 32'h10, 32'h11, 1'b0, 1'b1, 1'b0, 32, 5);
        start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        check("b2b busy", busy, 1);
        check("b2b done", done, 0);
        wait_done(-1, lat, bc);
        $display("op b2b lt=%0d eq=%0d latency=%0d", lt, eq, lat);
        check("b2b latency", lat, 1);
        check("b2b lt", lt, 1);
        tick();

        for (int k = 0; k < 40; k++) begin
            x = $urandom;
            case (k % 4)
                0: y = $urandom;
                1: y = x;
                2: y = x ^ (32'h1 << $urandom_range(0, W - 1));
                default: y = x ^ (32'h1 << $urandom_range(0, 3));
            endcase
            s = $urandom_range(0, 1);
            run_op($sformatf("rand%0d", k), x, y, s, ref_lt(x, y, s), (x == y), ref_lat(x, y), -1);
            if (k % 3 == 0) tick();
        end

        // Reset mid-scan: previous result lt=1 must be cleared and no done pulse may follow.
        run_op("pre_reset", 32'h0, 32'h1, 1'b0, 1'b1, 1'b0, 32, -1);
        start_op(32'hABCD_0000, 32'hABCD_0000, 1'b0);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        $display("op midscan_reset busy=%0d done=%0d lt=%0d eq=%0d", busy, done, lt, eq);
        check("midreset busy", busy, 0);
        check("midreset done", done, 0);
        check("midreset lt", lt, 0);
        check("midreset eq", eq, 0);
        pulses = 0;
        repeat (40) begin
            tick();
            if (done || busy) pulses++;
        end
        check("midreset no_activity", pulses, 0);

        // Reset and start on the same edge: reset wins.
        run_op("pre_rs", 32'h8000_0000, 32'h1, 1'b1, 1'b1, 1'b0, 1, -1);
        a = 32'h1; b = 32'h2; is_signed = 1'b0; start = 1'b1; reset = 1'b1;
        tick();
        start = 1'b0; reset = 1'b0;
        $display("op reset_and_start busy=%0d done=%0d lt=%0d eq=%0d", busy, done, lt, eq);
        check("rs busy", busy, 0);
        check("rs lt", lt, 0);
        check("rs eq", eq, 0);
        pulses = 0;
        repeat (40) begin
            tick();
            if (done || busy || lt || eq) pulses++;
        end
        check("rs no_activity", pulses, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
